// File: rtl/gamma_sequencer.sv
// gamma_sequencer: steps the race-logic filter through gamma cycles,
// driving gamma reset, input window and time-coded select steps.
module gamma_sequencer #(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  parameter  int RST_CYCLES        = 2,
  parameter  int CNT_W             = 16,
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [TW-1:0]    cfg_thr_g,
  input  logic [TW-1:0]    cfg_thr_l,
  output logic             filt_grst,
  output logic             eval_en,
  output logic             sel_greater,
  output logic             sel_lesser,
  output logic [TW-1:0]    t_now,
  output logic             cycle_start,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             busy
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW-1:0] THR_OFF = TW'(GAMMA_CYCLE_WIDTH);
  localparam logic [RW-1:0] R_LAST  = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    GRST = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [RW-1:0]    rc_q, rc_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    act_g_q, act_g_d;
  logic [TW-1:0]    act_l_q, act_l_d;
  logic [TW-1:0]    shd_g_q, shd_g_d;
  logic [TW-1:0]    shd_l_q, shd_l_d;
  logic             pend_q, pend_d;
  logic             done_d;
  logic             entry;
  logic             accept;
  logic             in_eval;

  // Sequencing, config handshake and next values of every output flop.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    rc_d    = rc_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    entry   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = EVAL;
          t_d     = '0;
          run_d   = cont;
          entry   = 1'b1;
        end
      end
      EVAL: begin
        run_d = run_q && !stop;
        if (t_q == T_LAST) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          t_d     = '0;
          rc_d    = '0;
          state_d = run_d ? GRST : IDLE;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      GRST: begin
        run_d = run_q && !stop;
        if (rc_q == R_LAST) begin
          if (run_d) begin
            state_d = EVAL;
            t_d     = '0;
            entry   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rc_d = rc_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Entry promotes the old shadow; a same-edge offer only lands in shadow.
    accept  = cfg_valid && !pend_q;
    act_g_d = entry ? shd_g_q : act_g_q;
    act_l_d = entry ? shd_l_q : act_l_q;
    shd_g_d = accept ? cfg_thr_g : shd_g_q;
    shd_l_d = accept ? cfg_thr_l : shd_l_q;
    pend_d  = accept || (pend_q && !entry);
    in_eval = (state_d == EVAL);
  end

  // State, thresholds and registered outputs.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      rc_q        <= '0;
      run_q       <= 1'b0;
      cnt_q       <= '0;
      act_g_q     <= THR_OFF;
      act_l_q     <= THR_OFF;
      shd_g_q     <= THR_OFF;
      shd_l_q     <= THR_OFF;
      pend_q      <= 1'b0;
      filt_grst   <= 1'b1;
      eval_en     <= 1'b0;
      sel_greater <= 1'b0;
      sel_lesser  <= 1'b0;
      t_now       <= '0;
      cycle_start <= 1'b0;
      cycle_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      rc_q        <= rc_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      act_g_q     <= act_g_d;
      act_l_q     <= act_l_d;
      shd_g_q     <= shd_g_d;
      shd_l_q     <= shd_l_d;
      pend_q      <= pend_d;
      filt_grst   <= !in_eval;
      eval_en     <= in_eval;
      sel_greater <= in_eval && (t_d >= act_g_d);
      sel_lesser  <= in_eval && (t_d >= act_l_d);
      t_now       <= in_eval ? t_d : '0;
      cycle_start <= in_eval && (t_d == '0);
      cycle_done  <= done_d;
      busy        <= (state_d != IDLE);
    end
  end

  assign cfg_ready = !pend_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_gamma_sequencer.sv
// tb_gamma_sequencer: table vectors, directed corner sequences and
// randomized traffic against a position-based reference model.
module tb_gamma_sequencer;

  localparam int G  = 16;
  localparam int R  = 2;
  localparam int TW = 5;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          grst = 1'b1;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [TW-1:0] cfg_thr_g = '0;
  logic [TW-1:0] cfg_thr_l = '0;
  logic          cfg_ready;
  logic          filt_grst;
  logic          eval_en;
  logic          sel_greater;
  logic          sel_lesser;
  logic [TW-1:0] t_now;
  logic          cycle_start;
  logic          cycle_done;
  logic [CW-1:0] cycle_cnt;
  logic          busy;

  int vec = 0;
  int errs = 0;

  always #5 aclk = ~aclk;

  gamma_sequencer #(
    .GAMMA_CYCLE_WIDTH(G),
    .RST_CYCLES(R),
    .CNT_W(CW)
  ) dut (
    .aclk(aclk),
    .grst(grst),
    .start(start),
    .cont(cont),
    .stop(stop),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_thr_g(cfg_thr_g),
    .cfg_thr_l(cfg_thr_l),
    .filt_grst(filt_grst),
    .eval_en(eval_en),
    .sel_greater(sel_greater),
    .sel_lesser(sel_lesser),
    .t_now(t_now),
    .cycle_start(cycle_start),
    .cycle_done(cycle_done),
    .cycle_cnt(cycle_cnt),
    .busy(busy)
  );

  // Model: position p in a period; -1 idle, 0..G-1 eval, G..G+R-1 reset gap.
  int m_p;
  bit m_run;
  int m_act_g, m_act_l, m_shd_g, m_shd_l;
  bit m_pend, m_done;
  int m_cnt;

  task automatic m_reset();
    m_p = -1;
    m_run = 0;
    m_act_g = G;
    m_act_l = G;
    m_shd_g = G;
    m_shd_l = G;
    m_pend = 0;
    m_done = 0;
    m_cnt = 0;
  endtask

  task automatic m_clock();
    bit entry;
    bit acc;
    entry = 0;
    if (grst) begin
      m_reset();
      return;
    end
    acc = cfg_valid && !m_pend;
    m_done = 0;
    if (m_p < 0) begin
      if (start && !stop) begin
        m_p = 0;
        m_run = cont;
        entry = 1;
      end
    end else begin
      m_run = m_run && !stop;
      if (m_p == G - 1) begin
        m_done = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_p = m_run ? G : -1;
      end else if (m_p == G + R - 1) begin
        m_p = m_run ? 0 : -1;
        entry = m_run;
      end else begin
        m_p++;
      end
    end
    if (entry) begin
      m_act_g = m_shd_g;
      m_act_l = m_shd_l;
      m_pend = 0;
    end
    if (acc) begin
      m_shd_g = int'(cfg_thr_g);
      m_shd_l = int'(cfg_thr_l);
      m_pend = 1;
    end
  endtask

  task automatic chk(string nm, longint act, longint exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_model();
    logic [28:0] a, e;
    bit ev;
    ev = (m_p >= 0) && (m_p < G);
    e = {!ev, ev, ev && (m_p >= m_act_g), ev && (m_p >= m_act_l),
         TW'(ev ? m_p : 0), m_p == 0, m_done, CW'(m_cnt),
         m_p >= 0, !m_pend};
    a = {filt_grst, eval_en, sel_greater, sel_lesser, t_now,
         cycle_start, cycle_done, cycle_cnt, busy, cfg_ready};
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL model @%0t: got %h expected %h", $time, a, e);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    m_clock();
    #1;
    cmp_model();
    @(negedge aclk);
  endtask

  task automatic cfg(int g, int l);
    cfg_valid = 1'b1;
    cfg_thr_g = TW'(g);
    cfg_thr_l = TW'(l);
    step();
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    int tg;
    int tl;
    int ng;
    int nl;
    int fg;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int ng, nl, fg, nd, ne, ns, ngr, nbad, rdy_bad, c0;
    int fgs[3];
    bit found;

    tbl[0] = '{2, 5, 14, 11, 2};
    tbl[1] = '{0, 16, 16, 0, 0};
    tbl[2] = '{15, 31, 1, 0, 15};
    tbl[3] = '{9, 1, 7, 15, 9};
    tbl[4] = '{16, 0, 0, 16, 99};

    m_reset();
    @(negedge aclk);
    step();
    step();
    chk("rst_filt_grst", filt_grst, 1);
    chk("rst_sel_g", sel_greater, 0);
    chk("rst_sel_l", sel_lesser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cnt", cycle_cnt, 0);
    grst = 1'b0;
    step();

    // Single-shot gammas over a table of threshold pairs.
    for (int i = 0; i < 5; i++) begin
      cfg(tbl[i].tg, tbl[i].tl);
      start = 1'b1;
      cont = 1'b0;
      ng = 0; nl = 0; fg = 99; nd = 0; ne = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        start = 1'b0;
        if (eval_en) begin
          ne++;
          if (sel_greater) begin
            ng++;
            if (fg == 99) fg = int'(t_now);
          end
          if (sel_lesser) nl++;
        end
        if (cycle_done) nd++;
      end
      chk($sformatf("tbl%0d_ng", i), ng, tbl[i].ng);
      chk($sformatf("tbl%0d_nl", i), nl, tbl[i].nl);
      chk($sformatf("tbl%0d_first_g", i), fg, tbl[i].fg);
      chk($sformatf("tbl%0d_done", i), nd, 1);
      chk($sformatf("tbl%0d_eval", i), ne, 16);
      chk($sformatf("tbl%0d_busy", i), busy, 0);
      chk($sformatf("tbl%0d_cnt", i), cycle_cnt, i + 1);
    end

    // Back-to-back with stop in the second gamma at t_now=7.
    c0 = int'(cycle_cnt);
    start = 1'b1;
    cont = 1'b1;
    ne = 0; ngr = 0; nd = 0; ns = 0; nbad = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      start = 1'b0;
      stop = 1'b0;
      if (cycle_start) ns++;
      if (eval_en) ne++;
      if (busy && !eval_en) ngr++;
      if (filt_grst == eval_en) nbad++;
      if (cycle_done) nd++;
      if (ns == 2 && eval_en && t_now == 7) stop = 1'b1;
    end
    chk("b2b_eval_cycles", ne, 32);
    chk("b2b_grst_cycles", ngr, 2);
    chk("b2b_done", nd, 2);
    chk("b2b_gammas", ns, 2);
    chk("b2b_filt_grst", nbad, 0);
    chk("b2b_cnt", cycle_cnt, (c0 + 2) % 65536);
    chk("b2b_idle", busy, 0);

    // Reprogramming mid-EVAL; a second offer stalls until the boundary.
    cfg(2, 16);
    start = 1'b1;
    cont = 1'b1;
    ns = 0; rdy_bad = 0; found = 0;
    fgs[0] = 99; fgs[1] = 99; fgs[2] = 99;
    for (int k = 0; k < 60; k++) begin
      step();
      start = 1'b0;
      stop = 1'b0;
      cfg_valid = 1'b0;
      if (cycle_start) ns++;
      if (ns > 0 && ns < 3 && eval_en && sel_greater && fgs[ns] == 99)
        fgs[ns] = int'(t_now);
      if (ns == 1 && ((eval_en && t_now >= 4) || (busy && !eval_en)) && cfg_ready)
        rdy_bad++;
      if (ns == 2 && cycle_start) begin
        found = 1;
        chk("cfg_ready_at_entry", cfg_ready, 1);
      end
      if (ns == 1 && eval_en && t_now == 3) begin
        cfg_valid = 1'b1;
        cfg_thr_g = 5'd9;
        cfg_thr_l = 5'd16;
      end
      if (ns == 1 && eval_en && t_now >= 5 && t_now <= 13) begin
        cfg_valid = 1'b1;
        cfg_thr_g = 5'd4;
        cfg_thr_l = 5'd16;
      end
      if (ns == 2 && eval_en && t_now == 7) stop = 1'b1;
    end
    chk("cfg_second_gamma_seen", found, 1);
    chk("cfg_gamma1_thr", fgs[1], 2);
    chk("cfg_gamma2_thr", fgs[2], 9);
    chk("cfg_ready_low", rdy_bad, 0);
    start = 1'b1;
    cont = 1'b0;
    fg = 99;
    for (int k = 0; k < 20; k++) begin
      step();
      start = 1'b0;
      if (eval_en && sel_greater && fg == 99) fg = int'(t_now);
    end
    chk("cfg_stalled_not_taken", fg, 9);

    // start and stop together stay idle.
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_eval", eval_en, 0);
    step();
    chk("startstop_busy2", busy, 0);

    // Async reset at EVAL t_now=10 with an update pending.
    start = 1'b1;
    cont = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      start = 1'b0;
      if (eval_en && t_now == 2) cfg_valid = 1'b1;
      else cfg_valid = 1'b0;
      if (eval_en && t_now == 10) found = 1;
    end
    cfg_valid = 1'b0;
    chk("grst_reached_t10", found, 1);
    chk("grst_pending_before", cfg_ready, 0);
    grst = 1'b1;
    #1;
    chk("grst_filt_grst", filt_grst, 1);
    chk("grst_eval_en", eval_en, 0);
    chk("grst_t_now", t_now, 0);
    chk("grst_busy", busy, 0);
    chk("grst_cnt", cycle_cnt, 0);
    chk("grst_cfg_ready", cfg_ready, 1);
    chk("grst_sel_g", sel_greater, 0);
    step();
    grst = 1'b0;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (cycle_done) nd++;
    end
    chk("grst_no_done", nd, 0);
    start = 1'b1;
    cont = 1'b0;
    step();
    start = 1'b0;
    chk("grst_restart_t", t_now, 0);
    chk("grst_restart_start", cycle_start, 1);
    chk("grst_restart_eval", eval_en, 1);
    for (int k = 0; k < 20; k++) step();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom % 6) == 0;
      cont = $urandom % 2;
      stop = ($urandom % 15) == 0;
      cfg_valid = ($urandom % 4) == 0;
      cfg_thr_g = TW'($urandom_range(0, 20));
      cfg_thr_l = TW'($urandom_range(0, 20));
      grst = ($urandom % 400) == 0;
      step();
    end
    grst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
